// File: rtl/fetch_pkg.sv
// Shared fetch-unit types: controller states and PC step.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    WAIT_MEM,
    DRAIN
  } fetch_state_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: next-PC select, stall/flush generation, redirect drain.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_f,
  input  logic             imem_ready,
  input  logic             hazard_stall,
  input  logic             branch_taken_e,
  input  logic [31:0]      branch_target_e,
  output logic [31:0]      pc_next,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic             imem_req,
  output logic [CNT_W-1:0] stall_cnt
);

  fetch_state_t state_q, state_n;
  logic [31:0]  redir_q, redir_n;
  logic [31:0]  drain_tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      redir_q <= '0;
    end else begin
      state_q <= state_n;
      redir_q <= redir_n;
    end
  end

  // A branch resolving during drain replaces the pending target at once.
  assign drain_tgt = branch_taken_e ? branch_target_e : redir_q;

  always_comb begin
    state_n  = state_q;
    redir_n  = redir_q;
    pc_next  = pc_f + PC_INC;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    imem_req = 1'b0;
    unique case (state_q)
      BOOT: begin
        pc_next = RESET_VEC;
        flush_d = 1'b1;
        state_n = RUN;
      end
      RUN, WAIT_MEM: begin
        imem_req = 1'b1;
        if (branch_taken_e) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
          if (imem_ready) begin
            pc_next = branch_target_e;
            state_n = RUN;
          end else begin
            stall_f = 1'b1;
            redir_n = branch_target_e;
            state_n = DRAIN;
          end
        end else begin
          if (hazard_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end else if (!imem_ready) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
          end
          state_n = imem_ready ? RUN : WAIT_MEM;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        flush_d  = 1'b1;
        flush_e  = branch_taken_e;
        pc_next  = drain_tgt;
        redir_n  = drain_tgt;
        stall_f  = !imem_ready;
        if (imem_ready) begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = BOOT;
      end
    endcase
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall_f),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: per-cycle expected controls queued and checked.
module tb_fetch_ctrl;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  // ctl = {stall_f, stall_d, flush_d, flush_e, imem_req}
  localparam logic [4:0] C_BOOT  = 5'b00100;
  localparam logic [4:0] C_RUN   = 5'b00001;
  localparam logic [4:0] C_BR    = 5'b00111;
  localparam logic [4:0] C_HAZ   = 5'b11011;
  localparam logic [4:0] C_MISS  = 5'b10101;
  localparam logic [4:0] C_BRMS  = 5'b10111;
  localparam logic [4:0] C_DRN   = 5'b10101;
  localparam logic [4:0] C_DRNR  = 5'b00101;
  localparam logic [4:0] C_DRNB  = 5'b10111;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        pc_ck;
    logic [4:0]  ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   pc_f;
  logic          imem_ready;
  logic          hazard_stall;
  logic          branch_taken_e;
  logic [31:0]   branch_target_e;
  logic [31:0]   pc_next;
  logic          stall_f;
  logic          stall_d;
  logic          flush_d;
  logic          flush_e;
  logic          imem_req;
  logic [CW-1:0] stall_cnt;

  exp_t          q[$];
  exp_t          e;
  logic [CW-1:0] exp_cnt;
  int            total = 0;
  int            bad = 0;
  int            n = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_VEC(32'h0000_0000),
    .CNT_W    (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_f           (pc_f),
    .imem_ready     (imem_ready),
    .hazard_stall   (hazard_stall),
    .branch_taken_e (branch_taken_e),
    .branch_target_e(branch_target_e),
    .pc_next        (pc_next),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .imem_req       (imem_req),
    .stall_cnt      (stall_cnt)
  );

  excl_a: assert property (@(negedge clk) disable iff (!rst_n)
    !(flush_d && stall_d));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] pcf,
                      input logic rdy, input logic haz, input logic br,
                      input logic [31:0] tgt, input logic [31:0] epc,
                      input logic pc_ck, input logic [4:0] ctl);
    exp_t x;
    pc_f            = pcf;
    imem_ready      = rdy;
    hazard_stall    = haz;
    branch_taken_e  = br;
    branch_target_e = tgt;
    x.tag   = $sformatf("%0d:%s", n, tag);
    x.pc    = epc;
    x.pc_ck = pc_ck;
    x.ctl   = ctl;
    x.cnt   = exp_cnt;
    q.push_back(x);
    n++;
    if (ctl[4] && exp_cnt != CMAX) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.pc_ck) check({e.tag, ".pc"}, pc_next, e.pc);
      check({e.tag, ".ctl"},
            {27'b0, stall_f, stall_d, flush_d, flush_e, imem_req},
            {27'b0, e.ctl});
      check({e.tag, ".cnt"}, {28'b0, stall_cnt}, {28'b0, e.cnt});
      check({e.tag, ".excl"}, {31'b0, flush_d & stall_d}, 32'b0);
    end
  end

  task automatic check_boot(input string tag);
    check({tag, ".pc"}, pc_next, 32'h0000_0000);
    check({tag, ".ctl"},
          {27'b0, stall_f, stall_d, flush_d, flush_e, imem_req},
          {27'b0, C_BOOT});
    check({tag, ".cnt"}, {28'b0, stall_cnt}, 32'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    pc_f = '0;
    imem_ready = 1'b1;
    hazard_stall = 1'b0;
    branch_taken_e = 1'b0;
    branch_target_e = '0;
    exp_cnt = '0;
    #2;
    check_boot("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    step("boot", 32'h0, 1, 0, 0, 32'h0, 32'h0000_0000, 1, C_BOOT);
    step("seq0", 32'h0, 1, 0, 0, 32'h0, 32'h0000_0004, 1, C_RUN);
    step("seq1", 32'h4, 1, 0, 0, 32'h0, 32'h0000_0008, 1, C_RUN);
    step("br", 32'h10, 1, 0, 1, 32'h100, 32'h0000_0100, 1, C_BR);
    step("haz0", 32'h20, 1, 1, 0, 32'h0, 32'h0000_0024, 1, C_HAZ);
    step("haz1", 32'h20, 1, 1, 0, 32'h0, 32'h0000_0024, 1, C_HAZ);
    step("unhz", 32'h20, 1, 0, 0, 32'h0, 32'h0000_0024, 1, C_RUN);
    step("brhz", 32'h24, 1, 1, 1, 32'h300, 32'h0000_0300, 1, C_BR);
    step("miss", 32'h300, 0, 0, 0, 32'h0, 32'h0000_0304, 1, C_MISS);
    step("wret", 32'h300, 1, 0, 0, 32'h0, 32'h0000_0304, 1, C_RUN);
    step("brms", 32'h304, 0, 0, 1, 32'h200, 32'h0, 0, C_BRMS);
    step("drn0", 32'h304, 0, 0, 0, 32'h0, 32'h0000_0200, 1, C_DRN);
    step("drn1", 32'h304, 0, 0, 0, 32'h0, 32'h0000_0200, 1, C_DRN);
    step("drnr", 32'h304, 1, 0, 0, 32'h0, 32'h0000_0200, 1, C_DRNR);
    step("post", 32'h200, 1, 0, 0, 32'h0, 32'h0000_0204, 1, C_RUN);
    step("wrap", 32'hFFFF_FFFC, 1, 0, 0, 32'h0, 32'h0000_0000, 1, C_RUN);
    step("brm2", 32'h204, 0, 0, 1, 32'h400, 32'h0, 0, C_BRMS);
    step("drbr", 32'h204, 0, 0, 1, 32'h500, 32'h0000_0500, 1, C_DRNB);
    step("drlw", 32'h204, 1, 0, 0, 32'h0, 32'h0000_0500, 1, C_DRNR);
    for (int i = 0; i < 9; i++) begin
      step("sat", 32'h40, 1, 1, 0, 32'h0, 32'h0000_0044, 1, C_HAZ);
    end
    step("satr", 32'h40, 1, 0, 0, 32'h0, 32'h0000_0044, 1, C_RUN);
    step("brm3", 32'h44, 0, 0, 1, 32'h600, 32'h0, 0, C_BRMS);

    // Reset pulse in the middle of a DRAIN cycle, away from any edge.
    imem_ready = 1'b0;
    branch_taken_e = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_boot("arst");
    exp_cnt = '0;
    @(posedge clk);
    #1;
    check_boot("arst_h");
    rst_n = 1'b1;
    step("boot2", 32'h0, 1, 0, 0, 32'h0, 32'h0000_0000, 1, C_BOOT);
    step("first", 32'h0, 1, 0, 0, 32'h0, 32'h0000_0004, 1, C_RUN);
    step("next", 32'h4, 1, 0, 0, 32'h0, 32'h0000_0008, 1, C_RUN);

    @(negedge clk);
    #1;
    check("q_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
